// File: rtl/jtag_tap_ctrl_if.sv
// Bundles the TAP controller's TMS input and all decoded control outputs.
// Latency: none; this file only carries wires between controller and scan logic.
// Backpressure: none; the TAP steps once per TCK edge and cannot be stalled.
// Optional macro TAP_SHIFT_CNT_EN adds the shift_cnt signal to both modports.
interface jtag_tap_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             TMS;
    logic [3:0]       tap_state;
    logic             test_logic_rst;
    logic             capturedr;
    logic             shiftdr;
    logic             clockdr;
    logic             updatedr;
    logic             captureir;
    logic             shiftir;
    logic             updateir;
    logic             tdo_sel;
    logic             tdo_en;
`ifdef TAP_SHIFT_CNT_EN
    logic [CNT_W-1:0] shift_cnt;

    modport master (
        output TMS,
        input  tap_state, test_logic_rst, capturedr, shiftdr, clockdr, updatedr,
        input  captureir, shiftir, updateir, tdo_sel, tdo_en, shift_cnt
    );

    modport slave (
        input  TMS,
        output tap_state, test_logic_rst, capturedr, shiftdr, clockdr, updatedr,
        output captureir, shiftir, updateir, tdo_sel, tdo_en, shift_cnt
    );
`else
    modport master (
        output TMS,
        input  tap_state, test_logic_rst, capturedr, shiftdr, clockdr, updatedr,
        input  captureir, shiftir, updateir, tdo_sel, tdo_en
    );

    modport slave (
        input  TMS,
        output tap_state, test_logic_rst, capturedr, shiftdr, clockdr, updatedr,
        output captureir, shiftir, updateir, tdo_sel, tdo_en
    );
`endif
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM stepped by TMS, decoded scan-control strobes.
// Latency: one TCK edge per state; outputs track the state register with no extra delay.
// Backpressure: none; every rising TCK edge advances the FSM unconditionally.
// Optional macro TAP_SHIFT_CNT_EN builds a saturating shift-bit counter (shift_cnt).
module jtag_tap_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic            TCK,
    input  logic            rst,
    jtag_tap_ctrl_if.slave  tap
);

    typedef enum logic [3:0] {
        EX2DR = 4'h0, EX1DR = 4'h1, SHDR  = 4'h2, PAUDR = 4'h3,
        SELIR = 4'h4, UPDDR = 4'h5, CAPDR = 4'h6, SELDR = 4'h7,
        EX2IR = 4'h8, EX1IR = 4'h9, SHIR  = 4'hA, PAUIR = 4'hB,
        RTI   = 4'hC, UPDIR = 4'hD, CAPIR = 4'hE, TLR   = 4'hF
    } tap_state_t;

    tap_state_t state;
    tap_state_t nxt;

    logic tlr_q, capdr_q, shdr_q, clkdr_q, upddr_q;
    logic capir_q, shir_q, updir_q, tdo_sel_q, tdo_en_q;

    // IEEE 1149.1 transition table
    function automatic tap_state_t next_of(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TLR:     n = tms ? TLR   : RTI;
            RTI:     n = tms ? SELDR : RTI;
            SELDR:   n = tms ? SELIR : CAPDR;
            SELIR:   n = tms ? TLR   : CAPIR;
            CAPDR:   n = tms ? EX1DR : SHDR;
            SHDR:    n = tms ? EX1DR : SHDR;
            EX1DR:   n = tms ? UPDDR : PAUDR;
            PAUDR:   n = tms ? EX2DR : PAUDR;
            EX2DR:   n = tms ? UPDDR : SHDR;
            UPDDR:   n = tms ? SELDR : RTI;
            CAPIR:   n = tms ? EX1IR : SHIR;
            SHIR:    n = tms ? EX1IR : SHIR;
            EX1IR:   n = tms ? UPDIR : PAUIR;
            PAUIR:   n = tms ? EX2IR : PAUIR;
            EX2IR:   n = tms ? UPDIR : SHIR;
            UPDIR:   n = tms ? SELDR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    assign nxt = next_of(state, tap.TMS);

    // State register plus strobes decoded from the next state, so each registered
    // strobe is high for exactly the cycles the state register holds its state
    always_ff @(posedge TCK) begin
        if (rst) begin
            state     <= TLR;
            tlr_q     <= 1'b1;
            capdr_q   <= 1'b0;
            shdr_q    <= 1'b0;
            clkdr_q   <= 1'b0;
            upddr_q   <= 1'b0;
            capir_q   <= 1'b0;
            shir_q    <= 1'b0;
            updir_q   <= 1'b0;
            tdo_sel_q <= 1'b0;
            tdo_en_q  <= 1'b0;
        end else begin
            state     <= nxt;
            tlr_q     <= (nxt == TLR);
            capdr_q   <= (nxt == CAPDR);
            shdr_q    <= (nxt == SHDR);
            clkdr_q   <= (nxt == CAPDR) || (nxt == SHDR);
            upddr_q   <= (nxt == UPDDR);
            capir_q   <= (nxt == CAPIR);
            shir_q    <= (nxt == SHIR);
            updir_q   <= (nxt == UPDIR);
            tdo_sel_q <= (nxt == CAPIR) || (nxt == SHIR) || (nxt == EX1IR) ||
                         (nxt == PAUIR) || (nxt == EX2IR) || (nxt == UPDIR);
            tdo_en_q  <= (nxt == SHDR) || (nxt == SHIR);
        end
    end

    assign tap.tap_state      = state;
    assign tap.test_logic_rst = tlr_q;
    assign tap.capturedr      = capdr_q;
    assign tap.shiftdr        = shdr_q;
    assign tap.clockdr        = clkdr_q;
    assign tap.updatedr       = upddr_q;
    assign tap.captureir      = capir_q;
    assign tap.shiftir        = shir_q;
    assign tap.updateir       = updir_q;
    assign tap.tdo_sel        = tdo_sel_q;
    assign tap.tdo_en         = tdo_en_q;

`ifdef TAP_SHIFT_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Bits shifted this visit: cleared on capture, saturating count of shift edges,
    // held through pause/exit so software can read the scan length afterwards
    always_ff @(posedge TCK) begin
        if (rst) begin
            cnt <= '0;
        end else if ((nxt == CAPDR) || (nxt == CAPIR)) begin
            cnt <= '0;
        end else if (((state == SHDR) || (state == SHIR)) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tap.shift_cnt = cnt;
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed TAP walks plus random TMS/rst.
// Latency: outputs are sampled 1 ns after each rising TCK edge.
// Backpressure: none; the bench drives TMS/rst on the falling edge.
module tb_jtag_tap_ctrl;
    localparam int CNT_W = 8;

    logic TCK = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model: spec transition table as lookup arrays, plus a counter
    int   nt0 [16];
    int   nt1 [16];
    int   ms   = 15;
    int   mcnt = 0;
    int   cmax = (1 << CNT_W) - 1;

    jtag_tap_ctrl_if #(.CNT_W(CNT_W)) tif ();

    jtag_tap_ctrl #(.CNT_W(CNT_W)) dut (
        .TCK (TCK),
        .rst (rst),
        .tap (tif)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic is_ir;
        int   nstrobe;
        is_ir = (ms == 'hA) || (ms == 'h9) || (ms == 'hB) || (ms == 'h8) ||
                (ms == 'hD) || (ms == 'hE);
        chk("tap_state",      32'(tif.tap_state),      32'(ms));
        chk("test_logic_rst", 32'(tif.test_logic_rst), 32'(ms == 15));
        chk("capturedr",      32'(tif.capturedr),      32'(ms == 6));
        chk("shiftdr",        32'(tif.shiftdr),        32'(ms == 2));
        chk("clockdr",        32'(tif.clockdr),        32'((ms == 6) || (ms == 2)));
        chk("updatedr",       32'(tif.updatedr),       32'(ms == 5));
        chk("captureir",      32'(tif.captureir),      32'(ms == 'hE));
        chk("shiftir",        32'(tif.shiftir),        32'(ms == 'hA));
        chk("updateir",       32'(tif.updateir),       32'(ms == 'hD));
        chk("tdo_sel",        32'(tif.tdo_sel),        32'(is_ir));
        chk("tdo_en",         32'(tif.tdo_en),         32'((ms == 2) || (ms == 'hA)));
        nstrobe = int'(tif.shiftdr) + int'(tif.shiftir) + int'(tif.updatedr) +
                  int'(tif.updateir) + int'(tif.capturedr) + int'(tif.captureir);
        chk("strobe_onehot",  32'(nstrobe <= 1),       32'd1);
`ifdef TAP_SHIFT_CNT_EN
        chk("shift_cnt",      32'(tif.shift_cnt),      32'(mcnt));
`endif
    endtask

    // One TCK edge with given TMS/rst, then model update and full output check
    task automatic step(input logic t, input logic r);
        @(negedge TCK);
        tif.TMS = t;
        rst     = r;
        @(posedge TCK);
        if (r) begin
            ms   = 15;
            mcnt = 0;
        end else begin
            if (((ms == 2) || (ms == 'hA)) && (mcnt < cmax)) mcnt++;
            ms = t ? nt1[ms] : nt0[ms];
            if ((ms == 6) || (ms == 'hE)) mcnt = 0;
        end
        #1;
        check_all();
    endtask

    task automatic walk(input logic t, input int exp_state);
        step(t, 1'b0);
        chk("walk_state", 32'(tif.tap_state), 32'(exp_state));
    endtask

    initial begin
        nt0 = '{'h2, 'h3, 'h2, 'h3, 'hE, 'hC, 'h2, 'h6,
                'hA, 'hB, 'hA, 'hB, 'hC, 'hC, 'hA, 'hC};
        nt1 = '{'h5, 'h5, 'h1, 'h0, 'hF, 'h7, 'h1, 'h4,
                'hD, 'hD, 'h9, 'h8, 'h7, 'h7, 'h9, 'hF};
        tif.TMS = 1'b1;

        // Reset from unknown state
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // TLR -> RTI -> SelDR -> CapDR -> ShDR
        walk(1'b0, 'hC);
        walk(1'b1, 'h7);
        walk(1'b0, 'h6);
        walk(1'b0, 'h2);

        // Reset from ShDR aborts scan
        step(1'b0, 1'b1);
        chk("rst_from_shdr", 32'(tif.tap_state), 32'hF);

        // Five TMS=1 from RTI reach TLR, then TLR holds
        walk(1'b0, 'hC);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("five_ones", 32'(tif.tap_state), 32'hF);
        walk(1'b1, 'hF);

        // DR scan with pause: ShDR x3 more, then 1,0,1,1,0
        walk(1'b0, 'hC);
        walk(1'b1, 'h7);
        walk(1'b0, 'h6);
        walk(1'b0, 'h2);
        for (int i = 0; i < 3; i++) walk(1'b0, 'h2);
        walk(1'b1, 'h1);
`ifdef TAP_SHIFT_CNT_EN
        chk("cnt_after_shift", 32'(tif.shift_cnt), 32'd4);
`endif
        walk(1'b0, 'h3);
        walk(1'b1, 'h0);
        walk(1'b1, 'h5);
        walk(1'b0, 'hC);

        // IR scan: RTI -> 7,4,E,A,9,D
        walk(1'b1, 'h7);
        walk(1'b1, 'h4);
        walk(1'b0, 'hE);
        walk(1'b0, 'hA);
        walk(1'b1, 'h9);
        walk(1'b1, 'hD);
        walk(1'b0, 'hC);

`ifdef TAP_SHIFT_CNT_EN
        // Long shift saturates the counter, then reset mid-shift clears it
        walk(1'b1, 'h7);
        walk(1'b0, 'h6);
        for (int i = 0; i < cmax + 20; i++) step(1'b0, 1'b0);
        chk("cnt_saturated", 32'(tif.shift_cnt), 32'(cmax));
        step(1'b0, 1'b1);
        chk("cnt_after_rst", 32'(tif.shift_cnt), 32'd0);
`endif

        // Random TMS with occasional reset
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));

        // Invariant: five TMS=1 from an arbitrary state reach TLR
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < int'($urandom_range(0, 6)); i++)
                step(1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
            chk("five_ones_rand", 32'(tif.tap_state), 32'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
